// File: rtl/event_scheduler.sv
// event_scheduler: latches per-source event strobes as pending entries
// (saturating count + first-occurrence timestamp) and serialises them,
// round-robin, into 256-bit messages on one AXI-Stream master port.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-high reset, clears all state
//   event_strobe     one bit per source, high one cycle per occurrence
//   event_enable     one bit per source, low drops and ignores the source
//   AXIS_OUT_TDATA   event message
//   AXIS_OUT_TVALID  message valid
//   AXIS_OUT_TREADY  downstream ready
//   events_pending   registered per-source pending flags
//
// Message layout:
//   [7:0]     source index + 1
//   [15:8]    occurrence count (saturating at 255)
//   [31:16]   sequence number at load
//   [63:32]   timestamp of the first occurrence
//   [247:64]  zero
//   [255:248] 8'h01

module event_scheduler #(
    parameter int DATA_WIDTH = 256,
    parameter int NUM_EVENTS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_strobe,
    input  logic [NUM_EVENTS-1:0] event_enable,
    output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
    output logic                  AXIS_OUT_TVALID,
    input  logic                  AXIS_OUT_TREADY,
    output logic [NUM_EVENTS-1:0] events_pending
);

    localparam int IW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]           ts;
    logic [15:0]           seq;
    logic [15:0]           seq_nxt;

    logic [NUM_EVENTS-1:0] pending;
    logic [NUM_EVENTS-1:0] eligible;
    logic [NUM_EVENTS-1:0] taken;
    logic [7:0]            count [NUM_EVENTS];
    logic [31:0]           stamp [NUM_EVENTS];

    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         grant;
    logic [IW-1:0]         rr_sel;
    int                    rr_idx;
    logic                  grant_vld;

    logic                  handshake;
    logic                  load;

    logic [DATA_WIDTH-1:0] tdata_q;
    logic [DATA_WIDTH-1:0] msg;

    // A source whose enable is low this cycle is never granted, so a
    // disable racing with a load cannot emit a stale entry.
    assign eligible  = pending & event_enable;
    assign handshake = (state == S_SEND) && AXIS_OUT_TREADY;
    assign load      = grant_vld && ((state == S_IDLE) || handshake);

    // The sequence number advances on the same edge a back-to-back
    // message is loaded, so that message carries the advanced value.
    assign seq_nxt = handshake ? seq + 16'd1 : seq;

    // Round-robin search starting just after the last granted source.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        rr_idx    = 0;
        rr_sel    = '0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            rr_idx = int'(last_grant) + 1 + k;
            if (rr_idx >= NUM_EVENTS) begin
                rr_idx = rr_idx - NUM_EVENTS;
            end
            rr_sel = IW'(rr_idx);
            if (!grant_vld && eligible[rr_sel]) begin
                grant_vld = 1'b1;
                grant     = rr_sel;
            end
        end
    end

    always_comb begin
        taken = '0;
        if (load) begin
            taken[grant] = 1'b1;
        end
    end

    always_comb begin
        msg                      = '0;
        msg[7:0]                 = 8'(grant) + 8'd1;
        msg[15:8]                = count[grant];
        msg[31:16]               = seq_nxt;
        msg[63:32]               = stamp[grant];
        msg[DATA_WIDTH-1 -: 8]   = 8'h01;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (handshake && !grant_vld) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        AXIS_OUT_TVALID = (state == S_SEND);
        AXIS_OUT_TDATA  = tdata_q;
        events_pending  = pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq <= '0;
        end else begin
            seq <= seq_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= IW'(NUM_EVENTS - 1);
            tdata_q    <= '0;
        end else if (load) begin
            last_grant <= grant;
            tdata_q    <= msg;
        end
    end

    // Per-source pending state. A strobe on the source being loaded this
    // edge starts a fresh entry; the outgoing message keeps the old count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                count[i] <= '0;
                stamp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (!event_enable[i]) begin
                    pending[i] <= 1'b0;
                end else if (event_strobe[i]) begin
                    if (!pending[i] || taken[i]) begin
                        pending[i] <= 1'b1;
                        count[i]   <= 8'd1;
                        stamp[i]   <= ts;
                    end else if (count[i] != 8'hFF) begin
                        count[i] <= count[i] + 8'd1;
                    end
                end else if (taken[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_event_scheduler.sv
// tb_event_scheduler: scoreboard bench for event_scheduler.
// Expected messages are queued at stimulus time and matched per beat.

module tb_event_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] event_strobe;
    logic [N-1:0] event_enable;
    logic [255:0] tdata;
    logic         tvalid;
    logic         tready;
    logic [N-1:0] events_pending;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           beat_cnt = 0;
    logic [31:0]  tb_ts;
    logic [15:0]  tb_seq = '0;
    logic [255:0] exp_q[$];

    always #5 clk = ~clk;

    event_scheduler #(
        .DATA_WIDTH(256),
        .NUM_EVENTS(N)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .event_strobe   (event_strobe),
        .event_enable   (event_enable),
        .AXIS_OUT_TDATA (tdata),
        .AXIS_OUT_TVALID(tvalid),
        .AXIS_OUT_TREADY(tready),
        .events_pending (events_pending)
    );

    // Reference cycle counter: value during cycle n equals n.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 32'd1;
    end

    function automatic logic [255:0] mk_msg(input logic [7:0] code,
                                            input logic [7:0] cnt,
                                            input logic [31:0] st);
        logic [255:0] m;
        m          = '0;
        m[7:0]     = code;
        m[15:8]    = cnt;
        m[63:32]   = st;
        m[255:248] = 8'h01;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic         stalled;
        logic [255:0] stall_data;
        logic [255:0] exp;
        stalled    = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    n_checks++;
                    if (tvalid !== 1'b1 || tdata !== stall_data)
                        $display("FAIL stall_hold: valid=%b data=%h want valid=1 data=%h",
                                 tvalid, tdata, stall_data);
                    else
                        n_pass++;
                end
                if (tvalid === 1'b1 && tready === 1'b1) begin
                    beat_cnt++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL beat_unexpected: got=%h want no beat", tdata);
                    end else begin
                        exp = exp_q.pop_front();
                        exp[31:16] = tb_seq;
                        if (tdata !== exp)
                            $display("FAIL beat_data: got=%h want=%h", tdata, exp);
                        else
                            n_pass++;
                    end
                    tb_seq  = tb_seq + 16'd1;
                    stalled = 1'b0;
                end else if (tvalid === 1'b1) begin
                    stalled    = 1'b1;
                    stall_data = tdata;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (tvalid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        n_checks++;
        if (tvalid !== 1'b1)
            $display("FAIL %s_timeout: tvalid=%b want 1", name, tvalid);
        else
            n_pass++;
    endtask

    task automatic reset_dut(input logic rdy);
        reset        = 1'b1;
        event_strobe = '0;
        event_enable = '1;
        tready       = rdy;
        step();
        step();
        exp_q.delete();
        tb_seq = '0;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        event_strobe = '0;
        event_enable = '1;
        tready       = 1'b0;
        step();
        step();
        n_checks++;
        if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got=%b want 0", tvalid);
        else n_pass++;
        n_checks++;
        if (tdata !== '0) $display("FAIL reset_tdata: got=%h want 0", tdata);
        else n_pass++;
        n_checks++;
        if (events_pending !== '0)
            $display("FAIL reset_pending: got=%b want 0", events_pending);
        else n_pass++;
    endtask

    task automatic test_single();
        int b0;
        reset_dut(1'b1);
        while (tb_ts < 32'd10) step();
        b0 = beat_cnt;
        event_strobe = 4'b0001;
        exp_q.push_back(mk_msg(8'd1, 8'd1, tb_ts));
        step();
        event_strobe = '0;
        n_checks++;
        if (events_pending !== 4'b0001 || tvalid !== 1'b0)
            $display("FAIL single_k1: pending=%b valid=%b want pending=0001 valid=0",
                     events_pending, tvalid);
        else n_pass++;
        step();
        n_checks++;
        if (tvalid !== 1'b1 || tdata[63:32] !== 32'd10)
            $display("FAIL single_k2: valid=%b stamp=%0d want valid=1 stamp=10",
                     tvalid, tdata[63:32]);
        else n_pass++;
        repeat (5) step();
        n_checks++;
        if (beat_cnt - b0 != 1 || exp_q.size() != 0)
            $display("FAIL single_beats: got=%0d left=%0d want 1 beat, 0 left",
                     beat_cnt - b0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_coalesce();
        tready       = 1'b0;
        event_strobe = 4'b0001;
        exp_q.push_back(mk_msg(8'd1, 8'd1, tb_ts));
        step();
        event_strobe = '0;
        wait_valid("coalesce_first");
        event_strobe = 4'b0100;
        exp_q.push_back(mk_msg(8'd3, 8'd255, tb_ts));
        repeat (300) step();
        event_strobe = '0;
        step();
        n_checks++;
        if (events_pending !== 4'b0100)
            $display("FAIL coalesce_pending: got=%b want 0100", events_pending);
        else n_pass++;
        tready = 1'b1;
        repeat (5) step();
        n_checks++;
        if (exp_q.size() != 0 || tvalid !== 1'b0)
            $display("FAIL coalesce_drain: left=%0d valid=%b want 0 left valid=0",
                     exp_q.size(), tvalid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] s;
        event_strobe = 4'b1111;
        s = tb_ts;
        for (int i = 0; i < N; i++)
            exp_q.push_back(mk_msg(8'(i + 1), 8'd1, s));
        step();
        event_strobe = '0;
        step();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (tvalid !== 1'b1)
                $display("FAIL rr_valid_%0d: got=%b want 1", i, tvalid);
            else n_pass++;
            step();
        end
        n_checks++;
        if (tvalid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL rr_end: valid=%b left=%0d want valid=0 left=0",
                     tvalid, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        reset_dut(1'b1);
        repeat (3) step();
        test_round_robin();
        step();
        test_round_robin();
    endtask

    task automatic test_collision();
        logic [31:0] s1;
        logic [31:0] s2;
        tready       = 1'b0;
        event_strobe = 4'b0010;
        s1 = tb_ts;
        step();
        s2 = tb_ts;
        step();
        event_strobe = '0;
        exp_q.push_back(mk_msg(8'd2, 8'd1, s1));
        exp_q.push_back(mk_msg(8'd2, 8'd1, s2));
        n_checks++;
        if (tvalid !== 1'b1 || events_pending !== 4'b0010)
            $display("FAIL collide_load: valid=%b pending=%b want valid=1 pending=0010",
                     tvalid, events_pending);
        else n_pass++;
        repeat (5) step();
        tready = 1'b1;
        repeat (4) step();
        n_checks++;
        if (exp_q.size() != 0 || tvalid !== 1'b0)
            $display("FAIL collide_drain: left=%0d valid=%b want 0 left valid=0",
                     exp_q.size(), tvalid);
        else n_pass++;
    endtask

    task automatic test_enable();
        int b0;
        tready       = 1'b1;
        b0           = beat_cnt;
        event_enable = 4'b0111;
        event_strobe = 4'b1000;
        step();
        event_strobe = '0;
        repeat (4) step();
        n_checks++;
        if (events_pending !== '0 || tvalid !== 1'b0 || beat_cnt != b0)
            $display("FAIL enable_ignore: pending=%b valid=%b beats=%0d want 0,0,0",
                     events_pending, tvalid, beat_cnt - b0);
        else n_pass++;
        event_enable = '1;
        tready       = 1'b0;
        event_strobe = 4'b0001;
        exp_q.push_back(mk_msg(8'd1, 8'd1, tb_ts));
        step();
        event_strobe = '0;
        wait_valid("enable_first");
        event_strobe = 4'b0100;
        step();
        event_strobe = '0;
        n_checks++;
        if (events_pending !== 4'b0100)
            $display("FAIL enable_set: got=%b want 0100", events_pending);
        else n_pass++;
        event_enable = 4'b1011;
        step();
        n_checks++;
        if (events_pending !== 4'b0000)
            $display("FAIL enable_clear: got=%b want 0000", events_pending);
        else n_pass++;
        event_enable = '1;
        tready       = 1'b1;
        repeat (4) step();
        n_checks++;
        if (exp_q.size() != 0 || beat_cnt - b0 != 1)
            $display("FAIL enable_drain: left=%0d beats=%0d want 0 left 1 beat",
                     exp_q.size(), beat_cnt - b0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int b0;
        tready       = 1'b0;
        event_strobe = 4'b0010;
        step();
        event_strobe = '0;
        wait_valid("rst_mid_first");
        event_strobe = 4'b1000;
        step();
        event_strobe = '0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (tvalid !== 1'b0 || tdata !== '0 || events_pending !== '0)
            $display("FAIL rst_mid_async: valid=%b pending=%b data=%h want all 0",
                     tvalid, events_pending, tdata);
        else n_pass++;
        step();
        step();
        exp_q.delete();
        tb_seq = '0;
        reset  = 1'b0;
        tready = 1'b1;
        b0     = beat_cnt;
        repeat (10) step();
        n_checks++;
        if (beat_cnt != b0 || tvalid !== 1'b0)
            $display("FAIL rst_mid_quiet: beats=%0d valid=%b want 0 beats valid=0",
                     beat_cnt - b0, tvalid);
        else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        event_strobe = '0;
        event_enable = '1;
        tready       = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_coalesce();
        test_back_to_back();
        test_collision();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/event_scheduler.md
# event_scheduler

Shares the single outbound event AXI-Stream channel among up to NUM_EVENTS independent event sources (underflow, overflow, timeout, etc.). Each source's single-cycle strobe is latched as a pending event with an occurrence count and timestamp. A round-robin scheduler serialises pending events into 256-bit event messages on the AXI-Stream master port. The block sits between the datapath's status strobes and the event-message stream to the host.

## Interface
- DATA_WIDTH, 256, output bus width; only 256 is supported.
- NUM_EVENTS, 4, number of event sources, 1..16.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- event_strobe  input  NUM_EVENTS  bit i high for one cycle = one occurrence of event i.
- event_enable  input  NUM_EVENTS  bit i low = source i ignored and its pending state cleared.
- AXIS_OUT_TDATA  output  DATA_WIDTH  event message.
- AXIS_OUT_TVALID  output  1  message valid.
- AXIS_OUT_TREADY  input  1  downstream ready.
- events_pending  output  NUM_EVENTS  registered per-source pending flags (status).

## Operation
- Per source i: pending[i], count[i] (8-bit, saturating at 255), stamp[i] (32 bits).
- Free-running 32-bit timestamp counter: +1 per clk, wraps 0xFFFFFFFF->0.
- 16-bit sequence number: +1 per accepted message, wraps 0xFFFF->0.
- Strobe on enabled source i, not pending: pending[i]<=1, count[i]<=1, stamp[i]<=current timestamp.
- Strobe on enabled source i, already pending: count[i] increments, saturating at 255; stamp unchanged.
- event_enable[i]=0: pending[i]<=0 and strobes ignored. A message already loaded in the output register is unaffected.
- Message layout:
  - [7:0] = i+1
  - [15:8] = count[i]
  - [31:16] = sequence number at load
  - [63:32] = stamp[i]
  - [247:64] = 0
  - [255:248] = 8'h01
- Round-robin grant: search starts at (last_grant+1) mod NUM_EVENTS; last_grant resets to NUM_EVENTS-1, so source 0 wins first.
- Load: copy the granted source's fields into TDATA and clear its pending bit in the same edge.
- Same-cycle load and strobe on the same source: the message carries the old count. The new strobe starts a fresh pending with count=1 and the current stamp.
- FSM:
  - IDLE: TVALID=0. If any pending bit is set, load the granted source, then go to SEND.
  - SEND: TVALID=1, TDATA held stable until TVALID&TREADY. On handshake the sequence number increments. If another source is pending, it is loaded in that same edge (TVALID stays 1, back-to-back). Otherwise go to IDLE.

## Timing
- Reset values: TVALID=0, TDATA=0, events_pending=0, all counts, stamps, timestamp and sequence = 0, FSM=IDLE.
- Reset asserted mid-transfer drops TVALID immediately (async) and discards the message and all pending events.
- Latency: strobe high in cycle k -> pending visible in cycle k+1 -> TVALID high in cycle k+2, with the FSM idle.
- Throughput: one message per clk while TREADY=1 and sources remain pending.
- TVALID never deasserts without a handshake, except on reset.
- TDATA changes only at load edges.
- A strobe arriving while its own message is stalled in SEND coalesces into a new pending entry; it is never lost, only counted.

## Test plan
- Single event: reset, TREADY=1, pulse strobe[0] at cycle 10 -> TVALID high at cycle 12; TDATA[7:0]=1, [15:8]=1, [31:16]=0, [255:248]=1, [63:32]=10; one beat only.
- Coalescing: TREADY=0, pulse strobe[2] 300 times -> when TREADY rises, one message with code 3 and count 255 (saturated); stamp is the first strobe's time.
- Round robin: strobes 0,1,2,3 together, TREADY=1 -> four back-to-back beats, codes 1,2,3,4, sequence 0..3, TVALID continuously high. Repeat all four -> order 1,2,3,4 again.
- Backpressure and same-source collision: source 1 message stalled, strobe[1] pulsed during the stall -> first beat has count 1 and stays stable. After its handshake, a second beat has code 2 and count 1.
- Enable and reset: strobe[3] with enable[3]=0 -> no message. Set source 2 pending, drop enable[2] -> pending cleared, no message. Assert reset during SEND -> TVALID low immediately; after release, nothing is sent.
